ro_puf_eval: RTL and testbench

Challenge sequencer and frequency comparator for the ring-oscillator PUF. It drives the select lines of two 32:1 RO multiplexers (A and B) from a 10-bit challenge and enables the oscillators. It counts rising edges on the two selected RO outputs over a fixed window and returns a one-bit response (A faster than B). It sits between the host/TinyTapeout I/O logic and the mux/RO array, as the consumer of the mux outputs and the producer of their selects.

---
 rtl/ro_puf_pkg.sv | 8 +
 rtl/ro_puf_eval_if.sv | 18 +
 rtl/ro_edge_counter.sv | 24 ++
 rtl/ro_puf_eval.sv | 70 +++++++
 tb/tb_ro_puf_eval.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared FSM state type and default parameters for the RO PUF evaluator
package ro_puf_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, COMPARE} state_t;
  localparam int DEF_SEL_W = 5;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_WINDOW_CYC = 1024;
endpackage

// File: rtl/ro_puf_eval_if.sv
// ro_puf_eval_if: host/mux-array side signals of the RO PUF evaluator
interface ro_puf_eval_if import ro_puf_pkg::*; #(parameter int SEL_W = DEF_SEL_W);
  logic start;
  logic [2*SEL_W-1:0] challenge;
  logic [SEL_W-1:0] sel_a;
  logic [SEL_W-1:0] sel_b;
  logic ro_en;
  logic ro_a;
  logic ro_b;
  logic busy;
  logic valid;
  logic response;
  logic err;
  modport master (output start, challenge, ro_a, ro_b,
                  input sel_a, sel_b, ro_en, busy, valid, response, err);
  modport slave (input start, challenge, ro_a, ro_b,
                 output sel_a, sel_b, ro_en, busy, valid, response, err);
endinterface

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronizes an async RO output and counts its rising edges, saturating
module ro_edge_counter import ro_puf_pkg::*; #(parameter int CNT_W = DEF_CNT_W) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);
  logic s1, s2, prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= ro;
      s2 <= s1;
      prev <= s2;
      if (clr) cnt <= '0;
      else if (cnt_en && s2 && !prev && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ro_puf_eval.sv
// ro_puf_eval: drives RO mux selects from a challenge, compares edge counts over a window
module ro_puf_eval import ro_puf_pkg::*; #(
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int WINDOW_CYC = DEF_WINDOW_CYC
) (
  input logic clk,
  input logic rst_n,
  ro_puf_eval_if.slave bus
);
  localparam int CYC_W = $clog2((WINDOW_CYC > SETTLE_CYC ? WINDOW_CYC : SETTLE_CYC) + 1);
  state_t state;
  logic [CYC_W-1:0] cyc;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic clr, cnt_en, same_sel;
  assign same_sel = bus.challenge[SEL_W-1:0] == bus.challenge[2*SEL_W-1:SEL_W];
  assign clr = state == IDLE && bus.start;
  // one extra COUNT cycle with counting off lets the compare see the final counts
  assign cnt_en = state == COUNT && cyc != CYC_W'(WINDOW_CYC);
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (.clk(clk), .rst_n(rst_n), .ro(bus.ro_a), .clr(clr), .cnt_en(cnt_en), .cnt(cnt_a));
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (.clk(clk), .rst_n(rst_n), .ro(bus.ro_b), .clr(clr), .cnt_en(cnt_en), .cnt(cnt_b));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cyc <= '0;
      bus.sel_a <= '0;
      bus.sel_b <= '0;
      bus.ro_en <= 1'b0;
      bus.busy <= 1'b0;
      bus.valid <= 1'b0;
      bus.response <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          bus.sel_a <= bus.challenge[SEL_W-1:0];
          bus.sel_b <= bus.challenge[2*SEL_W-1:SEL_W];
          bus.busy <= 1'b1;
          cyc <= '0;
          state <= same_sel ? COMPARE : SETTLE;
          bus.ro_en <= !same_sel;
          if (same_sel) begin
            bus.valid <= 1'b1;
            bus.err <= 1'b1;
            bus.response <= 1'b0;
          end
        end
        SETTLE: begin
          cyc <= cyc == CYC_W'(SETTLE_CYC - 1) ? '0 : cyc + 1'b1;
          if (cyc == CYC_W'(SETTLE_CYC - 1)) state <= COUNT;
        end
        COUNT: begin
          cyc <= cyc + 1'b1;
          if (cyc == CYC_W'(WINDOW_CYC)) begin
            state <= COMPARE;
            bus.ro_en <= 1'b0;
            bus.valid <= 1'b1;
            bus.response <= cnt_a > cnt_b;
            bus.err <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          bus.valid <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ro_puf_eval.sv
// tb_ro_puf_eval: randomized and directed checks of ro_puf_eval against a timeline model
module tb_ro_puf_eval;
  import ro_puf_pkg::*;
  localparam int S = DEF_SETTLE_CYC;
  int W [2] = '{1024, 64};
  int MX [2] = '{65535, 15};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [2] = '{1'b0, 1'b0};
  logic [9:0] ch [2] = '{10'd0, 10'd0};
  logic ra [2] = '{1'b0, 1'b0};
  logic rb [2] = '{1'b0, 1'b0};
  logic [4:0] osa [2];
  logic [4:0] osb [2];
  logic oen [2], obusy [2], oval [2], oresp [2], oerr [2];
  int pa [2] = '{2, 2};
  int pb [2] = '{2, 2};
  int kk [2] = '{0, 0};
  int ncyc = 0;
  int t0 [2] = '{0, 0};
  int n_chk = 0, n_fail = 0;
  bit act [2], eq [2];
  int t [2], ca [2], cb [2];
  bit [2:0] ha [2], hb [2];
  bit ea, eb;
  logic [4:0] esa [2], esb [2];
  bit een [2], ebusy [2], evalid [2], eresp [2], eerr [2];

  ro_puf_eval_if #(.SEL_W(5)) b0 ();
  ro_puf_eval_if #(.SEL_W(5)) b1 ();
  assign b0.start = st[0];
  assign b0.challenge = ch[0];
  assign b0.ro_a = ra[0];
  assign b0.ro_b = rb[0];
  assign b1.start = st[1];
  assign b1.challenge = ch[1];
  assign b1.ro_a = ra[1];
  assign b1.ro_b = rb[1];
  assign osa[0] = b0.sel_a;
  assign osb[0] = b0.sel_b;
  assign oen[0] = b0.ro_en;
  assign obusy[0] = b0.busy;
  assign oval[0] = b0.valid;
  assign oresp[0] = b0.response;
  assign oerr[0] = b0.err;
  assign osa[1] = b1.sel_a;
  assign osb[1] = b1.sel_b;
  assign oen[1] = b1.ro_en;
  assign obusy[1] = b1.busy;
  assign oval[1] = b1.valid;
  assign oresp[1] = b1.response;
  assign oerr[1] = b1.err;

  ro_puf_eval dut (.clk(clk), .rst_n(rst_n), .bus(b0));
  ro_puf_eval #(.CNT_W(4), .WINDOW_CYC(64)) dut_s (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  // RO waveforms are pure functions of a free-running count, so equal periods give identical phases
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      kk[i]++;
      ra[i] = pa[i] == 0 ? 1'($urandom_range(0, 1)) : 1'((kk[i] / pa[i]) % 2);
      rb[i] = pb[i] == 0 ? 1'($urandom_range(0, 1)) : 1'((kk[i] / pb[i]) % 2);
    end

  // Timeline model: t = edges since the accepting edge; an edge is seen 2 edges after it is sampled
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 0; t[i] = 0; ca[i] = 0; cb[i] = 0; ha[i] = 0; hb[i] = 0; eq[i] = 0;
        esa[i] = 0; esb[i] = 0; een[i] = 0; ebusy[i] = 0; evalid[i] = 0; eresp[i] = 0; eerr[i] = 0;
      end else begin
        ea = ha[i][1] && !ha[i][2];
        eb = hb[i][1] && !hb[i][2];
        ha[i] = {ha[i][1:0], ra[i]};
        hb[i] = {hb[i][1:0], rb[i]};
        evalid[i] = 0;
        if (act[i]) begin
          t[i]++;
          if (eq[i]) begin
            act[i] = 0; ebusy[i] = 0;
          end else begin
            if (t[i] >= S + 1 && t[i] <= S + W[i]) begin
              if (ea && ca[i] < MX[i]) ca[i]++;
              if (eb && cb[i] < MX[i]) cb[i]++;
            end
            if (t[i] == S + W[i] + 1) begin
              een[i] = 0; evalid[i] = 1; eresp[i] = ca[i] > cb[i]; eerr[i] = 0;
            end
            if (t[i] == S + W[i] + 2) begin
              act[i] = 0; ebusy[i] = 0;
            end
          end
        end else if (st[i]) begin
          act[i] = 1; t[i] = 0; ca[i] = 0; cb[i] = 0;
          esa[i] = ch[i][4:0]; esb[i] = ch[i][9:5];
          eq[i] = esa[i] == esb[i];
          ebusy[i] = 1;
          een[i] = !eq[i];
          if (eq[i]) begin
            evalid[i] = 1; eerr[i] = 1; eresp[i] = 0;
          end
        end
      end
    end

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, i, a, e, $time);
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk("sel_a", i, 32'(osa[i]), 32'(esa[i]));
      chk("sel_b", i, 32'(osb[i]), 32'(esb[i]));
      chk("ro_en", i, 32'(oen[i]), 32'(een[i]));
      chk("busy", i, 32'(obusy[i]), 32'(ebusy[i]));
      chk("valid", i, 32'(oval[i]), 32'(evalid[i]));
      chk("response", i, 32'(oresp[i]), 32'(eresp[i]));
      chk("err", i, 32'(oerr[i]), 32'(eerr[i]));
    end

  task automatic kick(input int i, input logic [9:0] c, input int p_a, input int p_b);
    pa[i] = p_a;
    pb[i] = p_b;
    ch[i] = c;
    st[i] = 1'b1;
    t0[i] = ncyc;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input logic [9:0] c);
    int g = 0;
    while (!oval[i] && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("done", i, 32'(oval[i]), 1);
    chk("latency", i, ncyc - t0[i], c[4:0] == c[9:5] ? 1 : S + W[i] + 2);
    chk("cnt_a", i, i == 1 ? 32'(dut_s.cnt_a) : 32'(dut.cnt_a), ca[i]);
    chk("cnt_b", i, i == 1 ? 32'(dut_s.cnt_b) : 32'(dut.cnt_b), cb[i]);
  endtask

  initial begin
    logic [9:0] c, c2;
    int nv;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 32'(obusy[0]), 0);
    chk("rst_sel_a", 0, 32'(osa[0]), 0);
    chk("rst_ro_en", 1, 32'(oen[1]), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    // A faster: 256 vs 128 rising edges
    c = 10'b00010_00001;
    kick(0, c, 2, 4);
    wait_done(0, c);
    chk("a_fast_resp", 0, 32'(oresp[0]), 1);
    chk("a_fast_err", 0, 32'(oerr[0]), 0);
    chk("model_ca", 0, ca[0], 256);
    chk("model_cb", 0, cb[0], 128);
    repeat (2) @(negedge clk);
    kick(0, c, 4, 2);
    wait_done(0, c);
    chk("b_fast_resp", 0, 32'(oresp[0]), 0);
    repeat (2) @(negedge clk);
    kick(0, c, 3, 3);
    wait_done(0, c);
    chk("equal_resp", 0, 32'(oresp[0]), 0);
    repeat (2) @(negedge clk);
    // same select: immediate error result, ROs never enabled
    c = 10'b00111_00111;
    kick(0, c, 2, 4);
    chk("same_ro_en", 0, 32'(oen[0]), 0);
    wait_done(0, c);
    chk("same_err", 0, 32'(oerr[0]), 1);
    chk("same_resp", 0, 32'(oresp[0]), 0);
    repeat (2) @(negedge clk);
    // saturation on the narrow instance: 16 edges clamp at 15
    c = 10'b00011_00100;
    kick(1, c, 2, 16);
    wait_done(1, c);
    chk("sat_cnt_a", 1, 32'(dut_s.cnt_a), 15);
    chk("sat_resp", 1, 32'(oresp[1]), 1);
    repeat (2) @(negedge clk);
    // start while busy is ignored
    c = 10'b01010_00101;
    c2 = 10'b11111_10000;
    kick(0, c, 2, 5);
    repeat (500) @(negedge clk);
    ch[0] = c2;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("busy_sel_a", 0, 32'(osa[0]), 32'(c[4:0]));
    chk("busy_sel_b", 0, 32'(osb[0]), 32'(c[9:5]));
    wait_done(0, c);
    // back-to-back: start in the valid cycle ignored, next cycle accepted
    ch[0] = c2;
    st[0] = 1'b1;
    @(negedge clk);
    chk("b2b_ignored", 0, 32'(osa[0]), 32'(c[4:0]));
    c = 10'b00001_01100;
    ch[0] = c;
    t0[0] = ncyc;
    @(negedge clk);
    st[0] = 1'b0;
    chk("b2b_accepted", 0, 32'(osa[0]), 32'(c[4:0]));
    wait_done(0, c);
    repeat (2) @(negedge clk);
    // asynchronous reset mid-COUNT
    kick(0, c, 2, 4);
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ro_en", 0, 32'(oen[0]), 0);
    chk("arst_busy", 0, 32'(obusy[0]), 0);
    chk("arst_sel_a", 0, 32'(osa[0]), 0);
    chk("arst_sel_b", 0, 32'(osb[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (1100) begin
      @(negedge clk);
      nv += int'(oval[0]);
    end
    chk("arst_no_valid", 0, nv, 0);
    kick(0, c, 2, 5);
    wait_done(0, c);
    chk("arst_resp", 0, 32'(oresp[0]), 1);
    // randomized evaluations on both instances
    for (int r = 0; r < 12; r++) begin
      int i;
      i = r % 3 == 0 ? 0 : 1;
      c = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) c[9:5] = c[4:0];
      repeat ($urandom_range(1, 4)) @(negedge clk);
      kick(i, c, $urandom_range(0, 6), $urandom_range(0, 6));
      wait_done(i, c);
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
